bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of requesting bus masters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum BUSY cycles without i_ack before error termination (>=2).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_m_bus_en, input, N_MASTERS, per-master request; each master holds it and its request fields stable until its o_m_ack.
REQ-006 SHALL have port i_m_wr_en, input, N_MASTERS, per-master write strobe.
REQ-007 SHALL have port i_m_addr, input, 32*N_MASTERS, per-master address; master k in bits [32k+31:32k].
REQ-008 SHALL have port i_m_wr_data, input, 32*N_MASTERS, per-master write data, same packing.
REQ-009 SHALL have port i_m_byte_en, input, 4*N_MASTERS, per-master byte enables, master k in [4k+3:4k].
REQ-010 SHALL have port i_m_lock, input, N_MASTERS, per-master atomic-sequence lock request.
REQ-011 SHALL have port o_m_ack, output, N_MASTERS, per-master one-cycle completion pulse.
REQ-012 SHALL have port o_m_err, output, N_MASTERS, per-master one-cycle timeout-error pulse, coincident with o_m_ack.
REQ-013 SHALL have port o_m_rd_data, output, 32, read data shared by all masters, valid with o_m_ack.
REQ-014 SHALL have ports o_bus_en, o_wr_en (1), o_addr, o_wr_data (32), o_byte_en (4), outputs: the shared slave request.
REQ-015 SHALL have ports i_ack (1), i_rd_data (32), inputs: slave completion and read data.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, LOCKED; register grant (index) and rr_ptr (last served index).
REQ-017 IDLE: if any i_m_bus_en bit set, SHALL grant the first requester found searching rr_ptr+1, rr_ptr+2, ... modulo N_MASTERS, and enter BUSY next cycle; else stay IDLE.
REQ-018 Latency SHALL be exactly one cycle from request seen in IDLE to o_bus_en=1.
REQ-019 BUSY: o_bus_en SHALL be 1; o_wr_en, o_addr, o_wr_data, o_byte_en SHALL be the granted master's fields, combinationally forwarded.
REQ-020 Outside BUSY: o_bus_en, o_wr_en, o_byte_en SHALL be 0; o_addr, o_wr_data SHALL be 0.
REQ-021 BUSY with i_ack=1: o_m_ack[grant]=1 and o_m_rd_data=i_rd_data in the same cycle (combinational); rr_ptr<=grant.
REQ-022 After ack: if i_m_lock[grant]=1 SHALL enter LOCKED, else IDLE.
REQ-023 LOCKED: owner i_m_bus_en=1 -> BUSY with same grant (no arbitration); else owner i_m_lock=0 -> IDLE; else stay LOCKED; other masters SHALL wait.
REQ-024 o_m_rd_data SHALL be 0 whenever no o_m_ack bit is set.
REQ-025 A cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without i_ack; on counter==TIMEOUT-1 without i_ack SHALL pulse o_m_ack[grant] and o_m_err[grant] with o_m_rd_data=0, set rr_ptr<=grant, drop any lock, and enter IDLE.
REQ-026 i_ack and timeout in the same cycle: ack SHALL win; o_m_err stays 0.
REQ-027 At most one o_m_ack bit SHALL be set per cycle; ack/err never issued outside BUSY; i_ack outside BUSY SHALL be ignored.
REQ-028 Requests from non-granted masters SHALL not affect the slave port; the arbiter gives one idle cycle between non-locked transactions.
REQ-029 A master deasserting i_m_bus_en during BUSY SHALL not terminate BUSY (protocol violation; arbiter waits for i_ack or timeout).

Reset
REQ-030 On i_rst=1 at a clock edge: state<=IDLE, grant<=0, rr_ptr<=N_MASTERS-1, counter<=0; all outputs 0 from the following cycle.
REQ-031 Reset during BUSY or LOCKED SHALL abort without ack or err; lock released.

Verification
REQ-032 Masters 0 and 1 request in the same cycle after reset -> master 0 served first, master 1 next; o_bus_en high one cycle after request; o_m_ack[0] then o_m_ack[1].
REQ-033 Both masters request continuously, slave acks after 1 cycle -> grants alternate 0,1,0,1 over 8 transactions.
REQ-034 Master 1 reads addr 0x0000_1000, slave returns 0xDEAD_BEEF after 3 cycles -> o_addr=0x0000_1000 while BUSY, o_m_ack[1]=1 with o_m_rd_data=0xDEAD_BEEF.
REQ-035 Master 0 sets i_m_lock and issues two transfers while master 1 requests -> both master-0 transfers complete before master 1 is granted.
REQ-036 TIMEOUT=4, slave never acks -> o_m_ack and o_m_err for the granted master pulse on the 4th BUSY cycle, o_m_rd_data=0, FSM back to IDLE.
REQ-037 i_rst asserted in the 2nd BUSY cycle, i_ack arrives next cycle -> no o_m_ack; o_bus_en=0 after the reset edge.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one 32-bit slave port among N_MASTERS masters.
// Supports locked back-to-back transfers and a per-transfer ack timeout.
module bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_MASTERS-1:0]     i_m_bus_en,
    input  logic [N_MASTERS-1:0]     i_m_wr_en,
    input  logic [32*N_MASTERS-1:0]  i_m_addr,
    input  logic [32*N_MASTERS-1:0]  i_m_wr_data,
    input  logic [4*N_MASTERS-1:0]   i_m_byte_en,
    input  logic [N_MASTERS-1:0]     i_m_lock,
    output logic [N_MASTERS-1:0]     o_m_ack,
    output logic [N_MASTERS-1:0]     o_m_err,
    output logic [31:0]              o_m_rd_data,
    output logic                     o_bus_en,
    output logic                     o_wr_en,
    output logic [31:0]              o_addr,
    output logic [31:0]              o_wr_data,
    output logic [3:0]               o_byte_en,
    input  logic                     i_ack,
    input  logic [31:0]              i_rd_data
);

    localparam int GW = $clog2(N_MASTERS);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_LOCKED} state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_cnt;

    logic            w_found;
    logic [GW-1:0]   w_next;
    logic [GW:0]     w_sum;
    logic            w_busy;
    logic            w_tmo;
    logic            w_done;
    logic            w_sel_wr;
    logic [31:0]     w_sel_addr;
    logic [31:0]     w_sel_data;
    logic [3:0]      w_sel_be;

    // Search starts one past the last served master, wrapping modulo N_MASTERS.
    always_comb begin
        w_found = 1'b0;
        w_next  = r_rr_ptr;
        w_sum   = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (GW+1)'(i);
            if (w_sum >= (GW+1)'(N_MASTERS))
                w_sum = w_sum - (GW+1)'(N_MASTERS);
            if (!w_found && i_m_bus_en[w_sum[GW-1:0]]) begin
                w_found = 1'b1;
                w_next  = w_sum[GW-1:0];
            end
        end
    end

    assign w_busy = (r_state == S_BUSY);
    assign w_tmo  = w_busy && !i_ack && (r_cnt == CW'(TIMEOUT-1));
    assign w_done = w_busy && (i_ack || w_tmo);

    always_comb begin
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_be   = '0;
        o_m_ack    = '0;
        o_m_err    = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (r_grant == GW'(k)) begin
                w_sel_wr   = i_m_wr_en[k];
                w_sel_addr = i_m_addr[32*k +: 32];
                w_sel_data = i_m_wr_data[32*k +: 32];
                w_sel_be   = i_m_byte_en[4*k +: 4];
                o_m_ack[k] = w_done;
                o_m_err[k] = w_tmo;
            end
        end
    end

    assign o_bus_en    = w_busy;
    assign o_wr_en     = w_busy & w_sel_wr;
    assign o_addr      = w_busy ? w_sel_addr : '0;
    assign o_wr_data   = w_busy ? w_sel_data : '0;
    assign o_byte_en   = w_busy ? w_sel_be   : '0;
    assign o_m_rd_data = (w_busy && i_ack) ? i_rd_data : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= GW'(N_MASTERS-1);
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_next;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_rr_ptr <= r_grant;
                        // A timeout always releases the lock.
                        r_state  <= (i_ack && i_m_lock[r_grant]) ? S_LOCKED : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (i_m_bus_en[r_grant]) begin
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end else if (!i_m_lock[r_grant]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
